dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (dmem) between the processor load/store path (requester 0) and the test/program loader port (requester 1). It arbitrates round-robin, registers the winning request, drives dmem for exactly one access cycle and returns a registered completion with read data. It sits between the datapath's memory stage and the dmem instance.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the load/store path (requester 0)
// and the test/program loader (requester 1). Round-robin arbitration, one
// registered ACCESS cycle, then a registered RESP cycle with done/err/rdata.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (requester 0 always wins a tie).
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       we,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q;
  logic             owner_q;
  logic             write_q;
  logic             reject_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic             lastServed_q;
`endif
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             err_q;
  logic             memWe_q;
  logic [WIDTH-1:0] memA_q;
  logic [WIDTH-1:0] memWd_q;
  logic [WIDTH-1:0] rdata_q;

  logic             winner_d;
  logic             reject_d;
  logic [WIDTH-1:0] addrWin_d;

  // Pick the winner among pending requests and classify its address.
  always_comb begin
    winner_d = 1'b0;
    if (req[0] && req[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      winner_d = 1'b0;
`else
      winner_d = ~lastServed_q;
`endif
    end else begin
      winner_d = req[1];
    end
    addrWin_d = winner_d ? addr1 : addr0;
    reject_d  = (addrWin_d[1:0] != 2'b00) || ((addrWin_d >> (SIZE + 2)) != '0);
  end

  // IDLE/ACCESS/RESP sequencer; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      reject_q     <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      lastServed_q <= 1'b1;
`endif
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      memWe_q      <= 1'b0;
      memA_q       <= '0;
      memWd_q      <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE, RESP: begin
          done_q <= 2'b00;
          err_q  <= 1'b0;
          if (|req) begin
            state_q  <= ACCESS;
            owner_q  <= winner_d;
            write_q  <= we[winner_d];
            reject_q <= reject_d;
            gnt_q    <= winner_d ? 2'b10 : 2'b01;
            memWe_q  <= we[winner_d] & ~reject_d;
            memA_q   <= addrWin_d;
            memWd_q  <= winner_d ? wdata1 : wdata0;
          end else begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          gnt_q        <= 2'b00;
          memWe_q      <= 1'b0;
          memA_q       <= '0;
          memWd_q      <= '0;
          done_q       <= owner_q ? 2'b10 : 2'b01;
          err_q        <= reject_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          lastServed_q <= owner_q;
`endif
          if (reject_q) begin
            rdata_q <= '0;
          end else if (!write_q) begin
            rdata_q <= mem_rd;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign mem_we = memWe_q;
  assign mem_a  = memA_q;
  assign mem_wd = memWd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural dmem, a completion
// scoreboard fed by the scenario tasks and drained by a done monitor.
module tb_dmem_arbiter;

  localparam int WIDTH = 32;
  localparam int SIZE  = 6;

  logic             clk;
  logic             reset;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]       gnt, done;
  logic             err;
  logic [WIDTH-1:0] rdata;
  logic             mem_we;
  logic [WIDTH-1:0] mem_a, mem_wd, mem_rd;

  logic [WIDTH-1:0] mem [0:(1<<SIZE)-1];

  typedef struct {
    logic             owner;
    logic [WIDTH-1:0] data;
    logic             err;
    logic             chkData;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: combinational read, synchronous write.
  assign mem_rd = mem[mem_a[SIZE+1:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[SIZE+1:2]] <= mem_wd;
  end

  // Completion monitor: every done pops one expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && done !== 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL done_unexpected got %b want 00", done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done !== (e.owner ? 2'b10 : 2'b01)) begin
          errors++;
          $display("[TB] FAIL done_owner got %b want %b", done, e.owner ? 2'b10 : 2'b01);
        end
        checks++;
        if (err !== e.err) begin
          errors++;
          $display("[TB] FAIL done_err got %b want %b", err, e.err);
        end
        if (e.chkData) begin
          checks++;
          if (rdata !== e.data) begin
            errors++;
            $display("[TB] FAIL done_rdata got %h want %h", rdata, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic owner, input logic [WIDTH-1:0] data,
                      input logic e, input logic chk);
    exp_t x;
    x.owner = owner; x.data = data; x.err = e; x.chkData = chk;
    sb.push_back(x);
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    reset = 1'b0;
    tick();
    checks++;
    if ({gnt, done, err, mem_we} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 000000", {gnt, done, err, mem_we});
    end
    checks++;
    if ({mem_a, mem_wd, rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h %h %h want 0 0 0", mem_a, mem_wd, rdata);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req = 2'b01; we = 2'b00; addr0 = 32'h14;
    push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    checks++;
    if (gnt !== 2'b01 || mem_a !== 32'h14 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_access got gnt=%b a=%h we=%b want 01 14 0", gnt, mem_a, mem_we);
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_write_read();
    req = 2'b10; we = 2'b10; addr1 = 32'h08; wdata1 = 32'h12345678;
    push(1'b1, '0, 1'b0, 1'b0);
    tick();
    checks++;
    if (gnt !== 2'b10 || mem_we !== 1'b1 || mem_a !== 32'h08 || mem_wd !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL write_access got gnt=%b we=%b a=%h wd=%h want 10 1 08 12345678",
               gnt, mem_we, mem_a, mem_wd);
    end
    req = 2'b00;
    tick();
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_resp_we got %b want 0", mem_we);
    end
    we = 2'b00; req = 2'b10;
    push(1'b1, 32'h12345678, 1'b0, 1'b1);
    tick();
    checks++;
    if (gnt !== 2'b10 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_back_access got gnt=%b we=%b want 10 0", gnt, mem_we);
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] expG;
    doReset();
    we = 2'b00; addr0 = 32'h14; addr1 = 32'h08;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
`else
      if (k % 2 == 0) push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
      else            push(1'b1, 32'h12345678, 1'b0, 1'b1);
`endif
    end
    req = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        expG = 2'b01;
`else
        expG = (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
`endif
      end else begin
        expG = 2'b00;
      end
      checks++;
      if (gnt !== expG) begin
        errors++;
        $display("[TB] FAIL contention_gnt cycle %0d got %b want %b", k, gnt, expG);
      end
      if (k == 7) req = 2'b00;
    end
    tick();
  endtask

  task automatic test_reject();
    req = 2'b01; we = 2'b01; addr0 = 32'h102; wdata0 = 32'hAAAA5555;
    push(1'b0, '0, 1'b1, 1'b1);
    tick();
    checks++;
    if (gnt !== 2'b01 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reject_misaligned got gnt=%b we=%b want 01 0", gnt, mem_we);
    end
    req = 2'b00;
    tick();
    req = 2'b01; addr0 = 32'h1 << (SIZE + 2); wdata0 = 32'h5555AAAA;
    push(1'b0, '0, 1'b1, 1'b1);
    tick();
    checks++;
    if (gnt !== 2'b01 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reject_range got gnt=%b we=%b want 01 0", gnt, mem_we);
    end
    req = 2'b00; we = 2'b00;
    tick();
    tick();
    checks++;
    if (mem[0] !== 32'h0BADF00D) begin
      errors++;
      $display("[TB] FAIL reject_mem got %h want 0badf00d", mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    tick();
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre_we got %b want 1", mem_we);
    end
    req = 2'b00; we = 2'b00;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_we got %b want 0", mem_we);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (done !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_done got %b want 00", done);
    end
    checks++;
    if (mem[8] !== 32'h88888888) begin
      errors++;
      $display("[TB] FAIL midreset_mem got %h want 88888888", mem[8]);
    end
    req = 2'b11; addr0 = 32'h14; addr1 = 32'h08;
    push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midreset_tie got %b want 01", gnt);
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    req = 2'b01; we = 2'b00; addr0 = 32'h14;
    push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_first got %b want 01", gnt);
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || done !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_resp got gnt=%b done=%b want 00 01", gnt, done);
    end
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_second got %b want 01", gnt);
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << SIZE); i++) mem[i] = 32'h0;
    mem[0] = 32'h0BADF00D;
    mem[5] = 32'hDEADBEEF;
    mem[8] = 32'h88888888;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
